// File: rtl/apb_cmd_master.sv
// APB4 requester: one command at a time over valid/ready, SETUP/ACCESS transfer, one-cycle response pulse.
// Optional access timeout is built only when APB_TIMEOUT_EN is defined.
module apb_cmd_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_slverr,
    output logic                rsp_timeout,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [ADDR_W-1:0]   paddr,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pready,
    input  logic                pslverr
);
    localparam int STRB_W = DATA_W / 8;

    if ((DATA_W % 8) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("apb_cmd_master: DATA_W must be a multiple of 8 and TIMEOUT_CYCLES at least 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_complete;
    logic                w_abort;
    logic                w_ready;
    logic                w_accept;
    logic                w_psel;
    logic                w_penable;
    logic                r_pwrite;
    logic [ADDR_W-1:0]   r_paddr;
    logic [DATA_W-1:0]   r_pwdata;
    logic [STRB_W-1:0]   r_pstrb;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_slverr;

    // cmd_ready is combinational from pready so a new command can follow with no idle cycle
    assign w_complete = (r_state == ST_ACCESS) & pready;
    assign w_ready    = (r_state == ST_IDLE) | w_complete;
    assign w_accept   = cmd_valid & w_ready;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_rsp_timeout;

    // Count is zero on every ACCESS entry; the limit is reached in the cycle that would make it TIMEOUT_CYCLES
    assign w_abort = (r_state == ST_ACCESS) & ~pready & (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge pclk) begin
        if (preset || r_state != ST_ACCESS) begin
            r_cnt <= '0;
        end else if (!pready) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_rsp_timeout <= 1'b0;
        end else if (w_complete) begin
            r_rsp_timeout <= 1'b0;
        end else if (w_abort) begin
            r_rsp_timeout <= 1'b1;
        end
    end

    assign rsp_timeout = r_rsp_timeout;
`else
    assign w_abort     = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_state_nxt = ST_SETUP;
            ST_SETUP:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (w_complete) begin
                    w_state_nxt = w_accept ? ST_SETUP : ST_IDLE;
                end else if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_psel    = 1'b0;
        w_penable = 1'b0;
        case (r_state)
            ST_SETUP:  w_psel = 1'b1;
            ST_ACCESS: begin
                w_psel    = 1'b1;
                w_penable = 1'b1;
            end
            default:   ;
        endcase
    end

    // Bus fields load only on accept, so they hold through the transfer and keep their values in IDLE
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
        end else if (w_accept) begin
            r_pwrite <= cmd_write;
            r_paddr  <= cmd_addr;
            r_pwdata <= cmd_write ? cmd_wdata : '0;
            r_pstrb  <= cmd_write ? cmd_strb : '0;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_slverr <= 1'b0;
        end else begin
            r_rsp_valid <= w_complete | w_abort;
            if (w_complete) begin
                r_rsp_rdata  <= r_pwrite ? '0 : prdata;
                r_rsp_slverr <= pslverr;
            end else if (w_abort) begin
                r_rsp_rdata  <= '0;
                r_rsp_slverr <= 1'b1;
            end
        end
    end

    assign cmd_ready  = w_ready;
    assign psel       = w_psel;
    assign penable    = w_penable;
    assign pwrite     = r_pwrite;
    assign paddr      = r_paddr;
    assign pwdata     = r_pwdata;
    assign pstrb      = r_pstrb;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_slverr = r_rsp_slverr;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master: expected responses queued at issue, compared when rsp_valid pulses.
module tb_apb_cmd_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic          pclk = 1'b0;
    logic          preset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_strb = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_slverr;
    logic          rsp_timeout;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;

    apb_cmd_master #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
        .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
        .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          slverr;
        logic          tmo;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   n_push = 0;
    int   n_rsp = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   rsp_cyc = 0;
    int   prev_rsp_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] rd, input logic sl, input logic to);
        exp_t e;
        e.rdata  = rd;
        e.slverr = sl;
        e.tmo    = to;
        sb.push_back(e);
        n_push++;
    endtask

    task automatic step;
        @(posedge pclk);
        #2;
    endtask

    initial forever begin
        @(posedge pclk);
        cyc++;
    end

    // Response monitor: every pulse must match the oldest queued expectation
    initial forever begin
        exp_t e;
        @(negedge pclk);
        if (preset === 1'b0 && cmd_valid && cmd_ready === 1'b1) acc_cyc = cyc;
        if (rsp_valid === 1'b1) begin
            prev_rsp_cyc = rsp_cyc;
            rsp_cyc = cyc;
            n_rsp++;
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_slverr", rsp_slverr, e.slverr);
                chk("rsp_timeout", rsp_timeout, e.tmo);
            end
        end
    end

    task automatic run_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                            input logic [SW-1:0] st, input int waits, input logic [DW-1:0] prd,
                            input logic sl, input logic slw);
        logic [DW-1:0] exp_wd;
        logic [SW-1:0] exp_st;
        int            held;
        exp_wd = wr ? wd : '0;
        exp_st = wr ? st : '0;
        held   = 0;
        push_exp(wr ? '0 : prd, sl, 1'b0);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st;
        pready = 1'b0; pslverr = slw;
        step;
        cmd_valid = 1'b0; cmd_addr = ~addr; cmd_wdata = ~wd; cmd_strb = ~st; cmd_write = ~wr;
        chk("setup_psel", psel, 1);
        chk("setup_penable", penable, 0);
        chk("setup_pwrite", pwrite, wr);
        chk("setup_paddr", paddr, addr);
        chk("setup_pwdata", pwdata, exp_wd);
        chk("setup_pstrb", pstrb, exp_st);
        if (psel && paddr == addr) held++;
        for (int i = 0; i <= waits; i++) begin
            step;
            chk("acc_psel", psel, 1);
            chk("acc_penable", penable, 1);
            chk("acc_paddr", paddr, addr);
            chk("acc_pwdata", pwdata, exp_wd);
            chk("acc_pstrb", pstrb, exp_st);
            if (psel && paddr == addr) held++;
            if (i == waits) begin
                pready = 1'b1; pslverr = sl; prdata = prd;
            end else begin
                pready = 1'b0; pslverr = slw; prdata = 32'hDEAD_0000 | DW'(i);
            end
        end
        step;
        pready = 1'b0; pslverr = 1'b0; prdata = 32'hBAD0_BAD0;
        chk("rsp_valid_hi", rsp_valid, 1);
        chk("done_psel", psel, 0);
        step;
        chk("rsp_valid_pulse", rsp_valid, 0);
        chk("rsp_latency", rsp_cyc - acc_cyc, waits + 3);
        chk("rdata_hold", rsp_rdata, wr ? '0 : prd);
        chk("addr_held_cycles", held, waits + 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        preset = 1'b1;
        step; step; step;
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_pstrb", pstrb, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_slverr", rsp_slverr, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        preset = 1'b0;
        #1;
        chk("idle_cmd_ready", cmd_ready, 1);

        // Single write, zero wait, then read with wait states
        run_xfer(1'b1, 32'h0C, 32'hA5, 4'h1, 0, 32'h0, 1'b0, 1'b0);
        run_xfer(1'b0, 32'h04, 32'hFFFF_FFFF, 4'hF, 3, 32'h5A, 1'b0, 1'b0);
        // Slave error only counts on the ready cycle
        run_xfer(1'b0, 32'h20, 32'h0, 4'h0, 0, 32'h1234_5678, 1'b1, 1'b0);
        run_xfer(1'b0, 32'h24, 32'h0, 4'h0, 2, 32'h0BAD_F00D, 1'b0, 1'b1);
        run_xfer(1'b1, 32'h28, 32'hCAFE_BABE, 4'hA, 2, 32'h0, 1'b1, 1'b1);

        // Back-to-back writes with cmd_valid held high
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h00; cmd_wdata = 32'h11; cmd_strb = 4'hF;
        pready = 1'b1;
        push_exp('0, 1'b0, 1'b0);
        step;
        chk("b2b_s1_psel", psel, 1);
        chk("b2b_s1_penable", penable, 0);
        chk("b2b_s1_paddr", paddr, 32'h00);
        cmd_addr = 32'h08; cmd_wdata = 32'h22; cmd_strb = 4'h3;
        push_exp('0, 1'b0, 1'b0);
        step;
        chk("b2b_a1_psel", psel, 1);
        chk("b2b_a1_penable", penable, 1);
        chk("b2b_a1_paddr", paddr, 32'h00);
        chk("b2b_a1_pwdata", pwdata, 32'h11);
        chk("b2b_a1_ready", cmd_ready, 1);
        step;
        cmd_valid = 1'b0;
        chk("b2b_s2_psel", psel, 1);
        chk("b2b_s2_penable", penable, 0);
        chk("b2b_s2_paddr", paddr, 32'h08);
        chk("b2b_s2_pwdata", pwdata, 32'h22);
        chk("b2b_s2_pstrb", pstrb, 4'h3);
        chk("b2b_rsp1", rsp_valid, 1);
        step;
        chk("b2b_a2_penable", penable, 1);
        chk("b2b_a2_rsp", rsp_valid, 0);
        step;
        pready = 1'b0;
        chk("b2b_rsp2", rsp_valid, 1);
        chk("b2b_idle_psel", psel, 0);
        step;
        chk("b2b_rsp_gap", rsp_cyc - prev_rsp_cyc, 2);

        // Reset during ACCESS: bus drops, no response
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; pready = 1'b0;
        step;
        cmd_valid = 1'b0;
        step;
        chk("mid_penable", penable, 1);
        preset = 1'b1;
        step;
        preset = 1'b0;
        chk("mid_rst_psel", psel, 0);
        chk("mid_rst_penable", penable, 0);
        chk("mid_rst_paddr", paddr, 0);
        chk("mid_rst_rsp", rsp_valid, 0);
        step;
        chk("mid_rst_rsp2", rsp_valid, 0);
        run_xfer(1'b1, 32'h44, 32'h0000_5555, 4'h3, 1, 32'h0, 1'b0, 1'b0);

`ifdef APB_TIMEOUT_EN
        push_exp('0, 1'b1, 1'b1);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10; pready = 1'b0;
        prdata = 32'h7777_7777;
        step;
        cmd_valid = 1'b0;
        n = 0;
        step;
        while (psel === 1'b1 && penable === 1'b1 && n < 40) begin
            n++;
            step;
        end
        chk("tmo_access_cycles", n, TO);
        chk("tmo_psel", psel, 0);
        chk("tmo_rsp_valid", rsp_valid, 1);
        chk("tmo_rsp_timeout", rsp_timeout, 1);
        chk("tmo_rsp_slverr", rsp_slverr, 1);
        step;
        run_xfer(1'b0, 32'h14, 32'h0, 4'h0, TO - 1, 32'h0000_0077, 1'b0, 1'b0);
`else
        n = 0;
        run_xfer(1'b0, 32'h14, 32'h0, 4'h0, 20, 32'h0000_0077, 1'b0, 1'b0);
`endif

        step; step;
        chk("sb_empty", sb.size(), 0);
        chk("rsp_count", n_rsp, n_push);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
